// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for the pong datapath: frame strobe, serve/play/pause/over FSM,
// score and lives bookkeeping.
//
//   state | meaning
//   IDLE  | power-up, waiting for the first start press
//   SERVE | ball recentred, waiting SERVE_FRAMES frames before play
//   PLAY  | datapath advances once per frame
//   PAUSE | frozen, a start press resumes play
//   OVER  | lives exhausted, score held, a start press begins a new game
module pong_game_ctrl #(
  parameter int unsigned FRAME_X      = 639,
  parameter int unsigned FRAME_Y      = 479,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SCORE_MAX    = 99
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic       start_btn_i,
  input  logic       ball_miss_i,
  input  logic       paddle_hit_i,
  output logic       game_enable_o,
  output logic       ball_reset_o,
  output logic [6:0] score_o,
  output logic [1:0] lives_o,
  output logic [2:0] state_o,
  output logic       game_over_o
);

  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [6:0]       SCORE_TOP  = 7'(SCORE_MAX);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] serve_cnt_q;
  logic [6:0]       score_q;
  logic [1:0]       lives_q;
  logic             frame_tick_q;
  logic             start_prev_q;
  logic             game_enable_q;
  logic             ball_reset_q;
  logic             game_over_q;

  logic pos_match;
  logic start_edge;

  assign pos_match  = (x_i == 10'(FRAME_X)) && (y_i == 9'(FRAME_Y));
  assign start_edge = start_btn_i && !start_prev_q;

  // game_enable_q is loaded from pos_match together with frame_tick_q, so it is
  // high exactly in the frame_tick cycle whenever the state in that cycle is PLAY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      serve_cnt_q   <= '0;
      score_q       <= '0;
      lives_q       <= '0;
      frame_tick_q  <= 1'b0;
      start_prev_q  <= 1'b0;
      game_enable_q <= 1'b0;
      ball_reset_q  <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      frame_tick_q  <= pos_match;
      start_prev_q  <= start_btn_i;
      game_enable_q <= 1'b0;
      ball_reset_q  <= 1'b0;
      game_over_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            state_q      <= S_SERVE;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            serve_cnt_q  <= '0;
            ball_reset_q <= 1'b1;
          end else if (state_q == S_OVER) begin
            game_over_q <= 1'b1;
          end
        end
        S_SERVE: begin
          if (frame_tick_q) begin
            if (serve_cnt_q == CNT_LAST) begin
              state_q     <= S_PLAY;
              serve_cnt_q <= '0;
            end else begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (ball_miss_i) begin
            if (lives_q > 2'd1) begin
              lives_q      <= lives_q - 2'd1;
              ball_reset_q <= 1'b1;
              state_q      <= S_SERVE;
              serve_cnt_q  <= '0;
            end else begin
              lives_q     <= '0;
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end
          end else begin
            if (paddle_hit_i && (score_q < SCORE_TOP)) begin
              score_q <= score_q + 7'd1;
            end
            if (start_edge) begin
              state_q <= S_PAUSE;
            end else begin
              game_enable_q <= pos_match;
            end
          end
        end
        S_PAUSE: begin
          if (start_edge) begin
            state_q       <= S_PLAY;
            game_enable_q <= pos_match;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign game_enable_o = game_enable_q;
  assign ball_reset_o  = ball_reset_q;
  assign score_o       = score_q;
  assign lives_o       = lives_q;
  assign state_o       = state_q;
  assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: small raster, directed game scenarios and random play,
// every cycle compared against a rule-level model of the game flow.
module tb_pong_game_ctrl;
  localparam int FX   = 15;
  localparam int FY   = 7;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int SF   = 2;
  localparam int NL   = 3;
  localparam int SMAX = 99;
  localparam int FRM  = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x;
  logic [8:0] y;
  logic       btn, miss, hit;
  logic       game_enable, ball_reset, game_over;
  logic [6:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  pong_game_ctrl #(
    .FRAME_X(FX), .FRAME_Y(FY), .SERVE_FRAMES(SF), .LIVES(NL), .SCORE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .y_i(y),
    .start_btn_i(btn), .ball_miss_i(miss), .paddle_hit_i(hit),
    .game_enable_o(game_enable), .ball_reset_o(ball_reset),
    .score_o(score), .lives_o(lives), .state_o(state), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ge_seen  = 0;
  int sx = 0, sy = 0;

  // reference model: game state by the rules, 0..4 as the published state codes
  int m_state, m_score, m_lives, m_cnt;
  bit m_prev, m_tick, m_ge, m_br, m_go;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_cnt = 0;
    m_prev = 0; m_tick = 0; m_ge = 0; m_br = 0; m_go = 0;
  endfunction

  function automatic void model_update(bit b, bit mi, bit h, bit match);
    bit se = b && !m_prev;
    m_br = 0;
    case (m_state)
      0, 4: if (se) begin
        m_state = 1; m_score = 0; m_lives = NL; m_cnt = 0; m_br = 1;
      end
      1: if (m_tick) begin
        if (m_cnt == SF - 1) begin m_state = 2; m_cnt = 0; end
        else m_cnt++;
      end
      2: if (mi) begin
        if (m_lives > 1) begin m_lives--; m_br = 1; m_state = 1; m_cnt = 0; end
        else begin m_lives = 0; m_state = 4; end
      end else begin
        if (h && m_score < SMAX) m_score++;
        if (se) m_state = 3;
      end
      3: if (se) m_state = 2;
      default: m_state = 0;
    endcase
    m_prev = b;
    m_tick = match;
    m_ge   = m_tick && (m_state == 2);
    m_go   = (m_state == 4);
  endfunction

  task automatic compare_all();
    if (game_enable === 1'b1) ge_seen++;
    chk("state", state, m_state);
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    chk("game_enable", game_enable, m_ge);
    chk("ball_reset", ball_reset, m_br);
    chk("game_over", game_over, m_go);
  endtask

  task automatic step(bit b, bit mi, bit h);
    bit match;
    @(negedge clk);
    x = 10'(sx); y = 9'(sy); btn = b; miss = mi; hit = h;
    match = (sx == FX) && (sy == FY);
    sx++;
    if (sx == W) begin sx = 0; sy = (sy + 1) % H; end
    @(posedge clk);
    model_update(b, mi, h, match);
    #1;
    compare_all();
  endtask

  task automatic wait_state(int target, int budget, string tag);
    int n = 0;
    while (m_state != target && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    chk(tag, state, target);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_ge"}, game_enable, 0);
    chk({tag, "_br"}, ball_reset, 0);
    chk({tag, "_go"}, game_over, 0);
  endtask

  task automatic lose_all_lives();
    for (int k = 0; k < NL; k++) begin
      wait_state(2, 4 * FRM, "lose_wait_play");
      step(0, 1, 0);
    end
  endtask

  initial begin
    bit b;
    rst_n = 1'b0; btn = 0; miss = 0; hit = 0; x = '0; y = '0;
    model_reset();
    #12;
    chk_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;

    // 1: idle, start, serve, first play frame
    ge_seen = 0;
    repeat (3 * FRM) step(0, 0, 0);
    chk("idle_ge_count", ge_seen, 0);
    step(1, 0, 0);
    chk("t1_ball_reset", ball_reset, 1);
    chk("t1_lives", lives, NL);
    chk("t1_state", state, 1);
    step(1, 0, 0);
    chk("t1_ball_reset_len", ball_reset, 0);
    wait_state(2, (SF + 1) * FRM + 4, "t1_to_play");
    ge_seen = 0;
    repeat (FRM) step(0, 0, 0);
    chk("t1_ge_per_frame", ge_seen, 1);

    // 2: score saturation
    for (int i = 0; i < 101; i++) begin
      step(0, 0, 1);
      if (i == 49) chk("t2_score_mid", score, 50);
      step(0, 0, 0);
    end
    chk("t2_score_sat", score, SMAX);

    // 3: lose all lives
    for (int k = 0; k < NL; k++) begin
      step(0, 1, 0);
      if (k < NL - 1) begin
        chk("t3_lives", lives, NL - 1 - k);
        chk("t3_br", ball_reset, 1);
        wait_state(2, (SF + 1) * FRM + 4, "t3_reserve");
      end
    end
    chk("t3_state", state, 4);
    chk("t3_go", game_over, 1);
    chk("t3_lives0", lives, 0);
    chk("t3_score_held", score, SMAX);

    // 4: miss and hit together
    step(1, 0, 0);
    chk("t4_restart_score", score, 0);
    step(0, 0, 0);
    wait_state(2, (SF + 1) * FRM + 4, "t4_play");
    repeat (5) begin step(0, 0, 1); step(0, 0, 0); end
    step(0, 1, 0);
    wait_state(2, (SF + 1) * FRM + 4, "t4_play2");
    step(0, 1, 1);
    chk("t4_score", score, 5);
    chk("t4_lives", lives, 1);
    chk("t4_state", state, 1);
    chk("t4_br", ball_reset, 1);

    // 5: pause, held button, resume
    wait_state(2, (SF + 1) * FRM + 4, "t5_play");
    step(1, 0, 0);
    chk("t5_pause", state, 3);
    ge_seen = 0;
    repeat (10 * FRM) step(1, 0, 1);
    chk("t5_pause_held", state, 3);
    chk("t5_pause_ge", ge_seen, 0);
    chk("t5_pause_score", score, 5);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t5_resume", state, 2);
    ge_seen = 0;
    repeat (FRM) step(1, 0, 0);
    chk("t5_resume_state", state, 2);
    chk("t5_resume_ge", ge_seen, 1);
    step(0, 0, 0);

    // 6: asynchronous reset mid-play, then restart from OVER
    step(0, 0, 1);
    @(negedge clk);
    #2;
    btn = 0; miss = 0; hit = 0; x = '0; y = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    lose_all_lives();
    chk("t6_over", state, 4);
    step(1, 0, 0);
    chk("t6_score", score, 0);
    chk("t6_lives", lives, NL);
    chk("t6_state", state, 1);

    // random play
    b = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 19) == 0) b = ~b;
      step(b, $urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the pong datapath. It derives a once-per-frame update strobe from the VGA scan position and gates it into the datapath's enable. It runs the serve/play/pause/game-over state machine and keeps score and lives. It sits between the VGA timing counters, the debounced start button and the pong datapath, which it restarts and throttles.

Parameters:
FRAME_X, 639, x coordinate at which the frame strobe fires
FRAME_Y, 479, y coordinate at which the frame strobe fires
SERVE_FRAMES, 60, frame strobes to wait in SERVE before play resumes
LIVES, 3, lives loaded at game start (1..3)
SCORE_MAX, 99, score saturation value

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
x  in  10  current scan column
y  in  9  current scan row
start_btn  in  1  debounced start/pause button, level
ball_miss  in  1  1-cycle pulse from datapath: ball passed the paddle
paddle_hit  in  1  1-cycle pulse from datapath: ball bounced off paddle
game_enable  out  1  1-cycle datapath update strobe, once per frame while playing
ball_reset  out  1  1-cycle pulse: datapath recentres ball/paddle
score  out  7  current score, saturating
lives  out  2  remaining lives
state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
game_over  out  1  high while state==OVER

Behaviour:
- Reset (async, rst_n low): state=IDLE, score=0, lives=0, game_enable=0, ball_reset=0, game_over=0, serve counter=0, start edge register=0. All outputs are registered.
- frame_tick: internal 1-cycle pulse, registered. High in the cycle after a cycle sampling x==FRAME_X && y==FRAME_Y.
- start_edge: start_btn high and previous sampled start_btn low. Only rising edges act; holding the button does nothing further.
- IDLE: game_enable=0. On start_edge go to SERVE; load score=0, lives=LIVES, serve counter=0; ball_reset=1 for one cycle.
- SERVE: game_enable=0. Serve counter increments on each frame_tick. When counter==SERVE_FRAMES-1 and frame_tick is high, go to PLAY and clear the counter. ball_miss, paddle_hit and start_edge are ignored.
- PLAY: game_enable=1 in the same cycle frame_tick=1, 0 otherwise.
  - paddle_hit: score+1, saturating at SCORE_MAX.
  - ball_miss with lives>1: lives-1, ball_reset pulse, go to SERVE, counter=0.
  - ball_miss with lives==1: lives=0, go to OVER.
  - start_edge: go to PAUSE.
- PAUSE: game_enable=0, counters frozen, miss/hit ignored. start_edge returns to PLAY. game_enable resumes at the next frame_tick, never retroactively.
- OVER: game_over=1, game_enable=0, score and lives held. start_edge starts a new game exactly as from IDLE (score=0, lives=LIVES, ball_reset, go to SERVE).
- Priority within one cycle in PLAY: ball_miss > start_edge > paddle_hit.
  - Miss with edge: the miss is processed, no pause.
  - Miss with hit: the hit is ignored.
  - Edge with hit: the score increments and PAUSE is entered.
- Serve and PLAY strobe alignment: if the SERVE->PLAY transition happens on a frame_tick cycle, game_enable stays 0 that cycle. The first game_enable is on the next frame.
- Illegal state encodings (5-7) go to IDLE on the next clock.
- Reset mid-game: immediate return to the reset values regardless of state. No ball_reset pulse is generated by reset itself.
- Widths: score compare/increment is 7-bit, never wraps. Serve counter is wide enough for SERVE_FRAMES-1 (6 bits at the default).

Test Plan:
1. Reset, with SERVE_FRAMES=2 and the scan running 640x480 -> state=0, game_enable never high. Pulse start_btn -> ball_reset high exactly 1 cycle, lives=3, state=1. After 2 frame ticks -> state=2. Next frame -> game_enable high 1 cycle, one cycle after (639,479).
2. In PLAY, drive 101 paddle_hit pulses -> score goes 0..99 and stays 99.
3. In PLAY with lives=3, three ball_miss pulses each followed by the serve wait -> lives 2, 1, then state=4, game_over=1, lives=0. Score is held.
4. ball_miss and paddle_hit in the same cycle at score=5, lives=2 -> score stays 5, lives=1, state=1, ball_reset pulse.
5. In PLAY, a start_btn rising edge -> state=3, no game_enable across 3 frames. Second edge -> state=2, game_enable on the following frame tick. Holding start_btn high for 10 frames -> no extra transitions.
6. Drop rst_n asynchronously mid-PLAY, between clock edges -> outputs take reset values immediately. In OVER, a start edge -> score=0, lives=3, state=1.
